// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle RV32I control unit:
//   - major opcode constants (inst[6:2])
//   - ALU control codes used by the controller directly
//   - FSM state enum and the decoded instruction class
// Optional macro MC_CTRL_TRAP_EN adds the TRAP state.
// ----------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [4:0] R_TYPE = 5'b01100;
    localparam logic [4:0] OP_IMM = 5'b00100;
    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] BRANCH = 5'b11000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
`ifdef MC_CTRL_TRAP_EN
        , S_TRAP
`endif
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILL
    } iclass_e;

endpackage

// File: rtl/mc_ctrl_inst_decode.sv
// ----------------------------------------------------------------------------
// inst_decode
// Combinational classifier for the instruction register contents.
// Ports:
//   inst_i        : IR contents
//   iclass_o      : instruction class (CLS_ILL when not supported)
//   legal_o       : instruction is one the controller can execute
//   alu_ctrl_o    : ALU operation for this instruction
//   alu_op2_sel_o : 0 = register operand 2, 1 = immediate
// ----------------------------------------------------------------------------
module inst_decode
    import ctrl_pkg::*;
#(
    parameter int INST_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic [INST_WIDTH-1:0]     inst_i,
    output iclass_e                   iclass_o,
    output logic                      legal_o,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_o,
    output logic                      alu_op2_sel_o
);

    logic [4:0] opc;
    logic [2:0] f3;
    logic       unused_bits;

    assign opc = inst_i[6:2];
    assign f3  = inst_i[14:12];
    assign unused_bits = ^{inst_i[INST_WIDTH-1:31], inst_i[29:15], inst_i[11:7]};

    always_comb begin
        iclass_o = CLS_ILL;
        if (inst_i[1:0] == 2'b11) begin
            case (opc)
                R_TYPE: iclass_o = CLS_R;
                OP_IMM: iclass_o = CLS_IMM;
                LOAD:   iclass_o = CLS_LOAD;
                STORE:  iclass_o = CLS_STORE;
                // only BEQ (000) and BNE (001) are supported
                BRANCH: if (f3[2:1] == 2'b00) iclass_o = CLS_BRANCH;
                default: iclass_o = CLS_ILL;
            endcase
        end
    end

    assign legal_o = (iclass_o != CLS_ILL);

    always_comb begin
        alu_ctrl_o    = ALU_CTRL_WIDTH'(ALU_ADD);
        alu_op2_sel_o = 1'b0;
        case (iclass_o)
            CLS_R:   alu_ctrl_o = ALU_CTRL_WIDTH'({inst_i[30], f3});
            CLS_IMM: begin
                // inst[30] is part of the immediate except for SRAI
                alu_ctrl_o    = ALU_CTRL_WIDTH'({(f3 == 3'b101) & inst_i[30], f3});
                alu_op2_sel_o = 1'b1;
            end
            CLS_LOAD, CLS_STORE: alu_op2_sel_o = 1'b1;
            CLS_BRANCH: alu_ctrl_o = ALU_CTRL_WIDTH'(ALU_SUB);
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// ----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Outputs are combinational from the state register and inst.
// Optional macro MC_CTRL_TRAP_EN: illegal instructions lock the FSM in
// TRAP with a sticky 'illegal' flag; otherwise they retire as a NOP.
// Ports:
//   clk, rst (async, active-high)
//   inst                      : IR contents
//   imem_rd_en / imem_ack     : fetch request / data valid
//   ir_wr_en                  : load the IR
//   dmem_rd_en, dmem_wr_en    : load / store request; dmem_ack completes
//   alu_ctrl, alu_op2_sel     : ALU op and operand 2 select; alu_zero in
//   reg_file_wr_en            : register write; reg_file_wr_back_sel 1=ALU
//   pc_wr_en, pc_src_sel      : PC update, 0 = PC+4, 1 = branch target
//   illegal                   : sticky illegal-instruction flag
// ----------------------------------------------------------------------------
module mc_ctrl
    import ctrl_pkg::*;
#(
    parameter int INST_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INST_WIDTH-1:0]     inst,
    output logic                      imem_rd_en,
    input  logic                      imem_ack,
    output logic                      ir_wr_en,
    output logic                      dmem_rd_en,
    output logic                      dmem_wr_en,
    input  logic                      dmem_ack,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
    output logic                      alu_op2_sel,
    input  logic                      alu_zero,
    output logic                      reg_file_wr_en,
    output logic                      reg_file_wr_back_sel,
    output logic                      pc_wr_en,
    output logic                      pc_src_sel,
    output logic                      illegal
);

    state_e                    state_q;
    iclass_e                   cls;
    logic                      legal;
    logic [ALU_CTRL_WIDTH-1:0] dec_alu_ctrl;
    logic                      dec_op2_sel;

    inst_decode #(
        .INST_WIDTH     (INST_WIDTH),
        .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
    ) u_dec (
        .inst_i        (inst),
        .iclass_o      (cls),
        .legal_o       (legal),
        .alu_ctrl_o    (dec_alu_ctrl),
        .alu_op2_sel_o (dec_op2_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (imem_ack) state_q <= S_DECODE;
                S_DECODE: begin
                    if (legal)
                        state_q <= S_EXEC;
                    else
`ifdef MC_CTRL_TRAP_EN
                        state_q <= S_TRAP;
`else
                        state_q <= S_FETCH;
`endif
                end
                S_EXEC: begin
                    case (cls)
                        CLS_R, CLS_IMM:       state_q <= S_WB;
                        CLS_LOAD, CLS_STORE:  state_q <= S_MEM;
                        default:              state_q <= S_FETCH;
                    endcase
                end
                S_MEM: if (dmem_ack) state_q <= (cls == CLS_LOAD) ? S_WB : S_FETCH;
                S_WB:  state_q <= S_FETCH;
`ifdef MC_CTRL_TRAP_EN
                S_TRAP: state_q <= S_TRAP;
`endif
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // rst gates everything so outputs are quiet for the whole reset pulse,
    // even though the state already reads FETCH.
    always_comb begin
        imem_rd_en           = 1'b0;
        ir_wr_en             = 1'b0;
        dmem_rd_en           = 1'b0;
        dmem_wr_en           = 1'b0;
        alu_ctrl             = '0;
        alu_op2_sel          = 1'b0;
        reg_file_wr_en       = 1'b0;
        reg_file_wr_back_sel = 1'b0;
        pc_wr_en             = 1'b0;
        pc_src_sel           = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_rd_en = 1'b1;
                    ir_wr_en   = imem_ack;
                end
                S_DECODE: begin
`ifndef MC_CTRL_TRAP_EN
                    // illegal instruction retires as a NOP
                    pc_wr_en = !legal;
`endif
                end
                S_EXEC: begin
                    alu_ctrl    = dec_alu_ctrl;
                    alu_op2_sel = dec_op2_sel;
                    if (cls == CLS_BRANCH) begin
                        pc_wr_en   = 1'b1;
                        // inst[12] distinguishes BNE from BEQ
                        pc_src_sel = inst[12] ? !alu_zero : alu_zero;
                    end
                end
                S_MEM: begin
                    alu_ctrl    = dec_alu_ctrl;
                    alu_op2_sel = dec_op2_sel;
                    if (cls == CLS_LOAD) begin
                        dmem_rd_en = 1'b1;
                    end else begin
                        dmem_wr_en = 1'b1;
                        pc_wr_en   = dmem_ack;
                    end
                end
                S_WB: begin
                    alu_ctrl             = dec_alu_ctrl;
                    alu_op2_sel          = dec_op2_sel;
                    reg_file_wr_en       = 1'b1;
                    reg_file_wr_back_sel = (cls != CLS_LOAD);
                    pc_wr_en             = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_TRAP_EN
    assign illegal = !rst && (state_q == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule
